// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
//   Shared MIPS definitions: ALU operation codes, primary opcodes, the
//   multiply/divide unit operation encodings and its FSM state encodings,
//   plus a small magnitude helper used by the divider.
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

   // ALU operation select
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_NOR = 4'd5,
      ALU_SLT = 4'd6,
      ALU_SLL = 4'd7
   } alu_op_e;

   // Primary opcodes (instruction bits 31:26)
   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] OPC_ADDIU   = 6'h09;
   localparam logic [5:0] OPC_LW      = 6'h23;
   localparam logic [5:0] OPC_SW      = 6'h2B;

   // Multiply/divide unit operations; codes 6 and 7 are no-ops
   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   // Multiply/divide unit FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;

   // Magnitude of a 32-bit value, treated as two's complement when sgn is set
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring-division step: shift the next dividend bit into the partial
//   remainder and subtract the divisor if it fits.
//   rem_i       partial remainder (always < divisor_i when divisor_i != 0)
//   dvd_bit_i   next dividend bit, MSB first
//   divisor_i   divisor magnitude
//   rem_o       next partial remainder
//   q_o         quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step (
   input  logic [31:0] rem_i,
   input  logic        dvd_bit_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic        q_o
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // NOTE: every output of a combinational block is assigned on every path, so
   // no latch can be inferred.
   always_comb begin
      shifted = {rem_i, dvd_bit_i};
      diff    = shifted - {1'b0, divisor_i};
      // Bit 32 of the 33-bit difference is the borrow: set means it did not fit.
      q_o     = ~diff[32];
      rem_o   = q_o ? diff[31:0] : shifted[31:0];
   end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   MIPS HI/LO multiply/divide unit. MULT/MULTU form the 64-bit product at
//   launch and hold busy for MUL_CYCLES cycles; DIV/DIVU run a 32-cycle
//   restoring divide plus one sign-fix cycle. MTHI/MTLO write HI/LO directly.
//   clk       clock, rising edge
//   reset     synchronous, active-low reset
//   start     launch request for op
//   op        operation (mdu_op_e encoding; 6-7 no-op)
//   rs_data   multiplicand / dividend / MTHI-MTLO source
//   rt_data   multiplier / divisor
//   flush     cancel an in-flight operation
//   busy      MUL or DIV in flight
//   done      one-cycle pulse after HI/LO take a MUL/DIV result
//   hi, lo    architectural HI and LO registers
// -----------------------------------------------------------------------------
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] a_q;        // raw first operand
   logic [31:0] b_q;        // raw second operand
   logic        signed_q;
   logic [63:0] prod_q;
   logic [31:0] dvd_q;      // dividend magnitude, becomes the quotient
   logic [31:0] rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod_d;
   logic [31:0] divisor_mag;
   logic [31:0] step_rem_d;
   logic        step_q_d;
   logic        neg_quot;
   logic        neg_rem;
   logic [31:0] fix_hi_d;
   logic [31:0] fix_lo_d;

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
   // correct for both signed and unsigned operands.
   always_comb begin
      ext_a = {32'd0, rs_data};
      ext_b = {32'd0, rt_data};
      if (op == MDU_MULT) begin
         ext_a = {{32{rs_data[31]}}, rs_data};
         ext_b = {{32{rt_data[31]}}, rt_data};
      end
      prod_d = ext_a * ext_b;
   end

   assign divisor_mag = mag32(b_q, signed_q);

   div_step u_div_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[31]),
      .divisor_i (divisor_mag),
      .rem_o     (step_rem_d),
      .q_o       (step_q_d)
   );

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   // Divide-by-zero bypasses the correction and reports all-ones / dividend.
   assign neg_quot = signed_q & (a_q[31] ^ b_q[31]);
   assign neg_rem  = signed_q & a_q[31];

   always_comb begin
      fix_lo_d = neg_quot ? (~dvd_q + 32'd1) : dvd_q;
      fix_hi_d = neg_rem  ? (~rem_q + 32'd1) : rem_q;
      if (b_q == 32'd0) begin
         fix_lo_d = 32'hFFFF_FFFF;
         fix_hi_d = a_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         signed_q <= 1'b0;
         prod_q   <= 64'd0;
         dvd_q    <= 32'd0;
         rem_q    <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     MDU_MULT, MDU_MULTU: begin
                        a_q      <= rs_data;
                        b_q      <= rt_data;
                        signed_q <= (op == MDU_MULT);
                        prod_q   <= prod_d;
                        cnt_q    <= 5'(MUL_CYCLES - 1);
                        state_q  <= ST_MUL;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        a_q      <= rs_data;
                        b_q      <= rt_data;
                        signed_q <= (op == MDU_DIV);
                        dvd_q    <= mag32(rs_data, op == MDU_DIV);
                        rem_q    <= 32'd0;
                        cnt_q    <= 5'd31;
                        state_q  <= ST_DIV;
                     end
                     MDU_MTHI: hi_q <= rs_data;
                     MDU_MTLO: lo_q <= rs_data;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == 5'd0) begin
                  hi_q    <= prod_q[63:32];
                  lo_q    <= prod_q[31:0];
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            ST_DIV: begin
               if (flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  // Quotient bits shift in as dividend bits shift out.
                  rem_q <= step_rem_d;
                  dvd_q <= {dvd_q[30:0], step_q_d};
                  if (cnt_q == 5'd0) state_q <= ST_FIX;
                  else               cnt_q   <= cnt_q - 5'd1;
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               if (!flush) begin
                  hi_q   <= fix_hi_d;
                  lo_q   <= fix_lo_d;
                  done_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed self-checking bench for mul_div_unit (MUL_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   mul_div_unit #(.MUL_CYCLES(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      tick();
      start   = 1'b0;
   endtask

   // Counts busy cycles (the launch cycle already elapsed counts as one).
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
      tick(); tick();
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      reset = 1'b1;
   endtask

   task automatic test_mult();
      int n;
      issue(3'd0, 32'hFFFF_FFFD, 32'd5);
      wait_idle(n);
      checks++; if (n !== 4)              begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 4", n); end
      checks++; if (done !== 1'b1)        begin errors++; $display("FAIL mult_done: got %b expected 1", done); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
      tick();
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_multu();
      int n;
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      checks++; if (n !== 4)              begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 4", n); end
      checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
      checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
      tick();
   endtask

   task automatic test_div_ignore_start();
      int n;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         // A MULTU request during busy cycle 5 must be dropped.
         if (n == 5) begin start = 1'b1; op = 3'd1; rs_data = 32'd9; rt_data = 32'd9; end
         else start = 1'b0;
         tick();
      end
      start = 1'b0;
      checks++; if (n !== 33)             begin errors++; $display("FAIL div_busy_cycles: got %0d expected 33", n); end
      checks++; if (done !== 1'b1)        begin errors++; $display("FAIL div_done: got %b expected 1", done); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      tick(); tick(); tick(); tick(); tick();
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL div_ignored_start_busy: got %b expected 0", busy); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_ignored_start_lo: got %h expected fffffffd", lo); end
   endtask

   task automatic test_div_corner();
      int n;
      issue(3'd3, 32'd100, 32'd0);
      wait_idle(n);
      checks++; if (n !== 33)             begin errors++; $display("FAIL divu0_busy_cycles: got %0d expected 33", n); end
      checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
      checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi: got %h expected 00000064", hi); end
      tick();
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
      checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
      tick();
      // Signed divide-by-zero keeps the raw dividend in HI.
      issue(3'd2, 32'hFFFF_FFF9, 32'd0);
      wait_idle(n);
      checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
      checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_hi: got %h expected fffffff9", hi); end
      tick();
   endtask

   task automatic test_flush();
      int n;
      int pulses;
      issue(3'd5, 32'd0, 32'd0);
      issue(3'd4, 32'h11, 32'd0);
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL mthi_done: got %b expected 0", done); end
      checks++; if (hi !== 32'h11)  begin errors++; $display("FAIL mthi_hi: got %h expected 00000011", hi); end
      issue(3'd2, 32'd50, 32'd7);
      n = 1;
      while (n < 10) begin n++; tick(); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h11)  begin errors++; $display("FAIL flush_hi: got %h expected 00000011", hi); end
      checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL flush_lo: got %h expected 00000000", lo); end
      pulses = (done === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin tick(); if (done === 1'b1) pulses++; end
      checks++; if (pulses !== 0)   begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); end
      checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL flush_lo_later: got %h expected 00000000", lo); end
      // flush together with start in IDLE discards the start
      flush = 1'b1;
      issue(3'd4, 32'hDEAD, 32'd0);
      flush = 1'b0;
      checks++; if (hi !== 32'h11)  begin errors++; $display("FAIL flush_start_hi: got %h expected 00000011", hi); end
      flush = 1'b1;
      issue(3'd0, 32'd3, 32'd3);
      flush = 1'b0;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int n;
      issue(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
      wait_idle(n);
      checks++; if (lo !== 32'hC000_0001) begin errors++; $display("FAIL b2b_div_lo: got %h expected c0000001", lo); end
      checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL b2b_div_hi: got %h expected 00000001", hi); end
      // Launch in the same cycle done is high.
      issue(3'd0, 32'h8000_0000, 32'h8000_0000);
      checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL b2b_mult_launch: got %b expected 1", busy); end
      wait_idle(n);
      checks++; if (n !== 4)              begin errors++; $display("FAIL b2b_mult_cycles: got %0d expected 4", n); end
      checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL b2b_mult_hi: got %h expected 40000000", hi); end
      checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL b2b_mult_lo: got %h expected 00000000", lo); end
      tick();
   endtask

   task automatic test_reset_midop();
      issue(3'd5, 32'h1234, 32'd0);
      checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo: got %h expected 00001234", lo); end
      issue(3'd0, 32'd7, 32'd9);
      tick();
      reset = 1'b0;
      tick();
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'd0)    begin errors++; $display("FAIL midreset_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'd0)    begin errors++; $display("FAIL midreset_lo: got %h expected 0", lo); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
      reset = 1'b1;
      issue(3'd5, 32'h5, 32'd0);
      checks++; if (lo !== 32'h5)    begin errors++; $display("FAIL first_edge_mtlo: got %h expected 00000005", lo); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL first_edge_busy: got %b expected 0", busy); end
      tick(); tick(); tick(); tick(); tick();
      checks++; if (hi !== 32'd0)    begin errors++; $display("FAIL midreset_no_late_hi: got %h expected 0", hi); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div_ignore_start();
      test_div_corner();
      test_flush();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4, sets the number of busy cycles for MULT/MULTU (legal range 1..8).
REQ-002 clk  in  1  clock; every register updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  launch request for the operation on op; sampled on the rising edge.
REQ-005 op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; codes 6-7 are treated as no-op.
REQ-006 rs_data  in  32  first operand (multiplicand or dividend), or the source value for MTHI/MTLO.
REQ-007 rt_data  in  32  second operand (multiplier or divisor).
REQ-008 flush  in  1  cancels an in-flight operation.
REQ-009 busy  out  1  high while a MUL or DIV operation is in flight; the pipeline stalls MFHI/MFLO on it.
REQ-010 done  out  1  one-cycle pulse when hi/lo receive a MUL or DIV result.
REQ-011 hi  out  32  architectural HI register.
REQ-012 lo  out  32  architectural LO register.

Function
REQ-013 The FSM SHALL have four states: IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-014 In IDLE, start with op 0-3 SHALL latch both operands and the signedness.
  - op 0-1: go to MUL and load counter = MUL_CYCLES-1.
  - op 2-3: go to DIV and load counter = 31.
REQ-015 In IDLE, start with op 4 (MTHI) SHALL load hi <= rs_data on that edge; start with op 5 (MTLO) SHALL load lo <= rs_data on that edge.
  - busy stays low; done is not pulsed.
REQ-016 start while busy SHALL be ignored; operands are not re-latched.
REQ-017 MUL SHALL compute the full 64-bit product {hi,lo}.
  - Signed (two's complement) for MULT, unsigned for MULTU.
  - hi/lo are written on the edge where counter==0; state returns to IDLE and done pulses the following cycle.
  - Result: busy high for exactly MUL_CYCLES cycles.
REQ-018 DIV SHALL run a restoring divide on operand magnitudes, producing one quotient bit per cycle for 32 cycles, then enter FIX.
REQ-019 FIX SHALL apply sign correction and write hi/lo, then return to IDLE.
  - Quotient (lo) truncates toward zero; remainder (hi) takes the sign of the dividend.
  - Sign correction applies to DIV only.
  - Result: busy high for 33 cycles; done pulses the cycle after FIX.
REQ-020 A divisor of 0 SHALL take the same latency and give lo=0xFFFFFFFF, hi=dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 flush while busy SHALL force IDLE on the next edge.
  - hi/lo keep their prior values; done stays low.
  - flush in IDLE has no effect.
REQ-023 flush together with start in IDLE SHALL discard the start.
REQ-024 hi and lo SHALL change only on REQ-015, REQ-017, REQ-019 and reset.

Reset
REQ-025 While reset=0 at a rising edge, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, and clear the operand registers.
REQ-026 Reset SHALL override start, flush and any in-flight operation; no partial result reaches hi/lo.
REQ-027 The first start SHALL be accepted on the first edge with reset=1.

Structure
REQ-028 The op encodings (MDU_MULT..MDU_MTLO) and FSM state encodings SHALL live in the shared MIPS definitions package, alongside the existing ALU and opcode constants.
REQ-029 The per-cycle restoring step SHALL be one sub-module, div_step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Purely combinational, instantiated once.
REQ-030 The multiply SHALL be a single 64-bit product registered at launch; the MUL counter only models latency.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - MULT rs=0xFFFFFFFD (-3), rt=5 -> busy for 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse.
  - MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 33 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; a start issued at busy cycle 5 is ignored.
  - DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - MTHI 0x11, then DIV 50/7, flush at busy cycle 10 -> IDLE next edge, hi=0x11, lo=0, no done pulse.
  - MTLO 0x1234, then MULT started, reset=0 at busy cycle 2 -> hi=lo=0, busy=0; MTLO 0x5 on the first edge with reset=1 -> lo=0x5.
